axum_uart_rx: RTL and testbench

- Serial receive stage of the axum UART. It sits between the rx_i pad and the RX FIFO inside the UART core.
- Synchronises the line and oversamples it at 16x baud using a divisor-driven tick.
- Deframes 8N1 characters, LSB first, and pushes each completed byte into the RX FIFO.
- Reports framing and overrun errors to the bus-facing register block as sticky flags.

---
 rtl/axum_uart_pkg.sv | 14 +
 rtl/axum_uart_baud_gen.sv | 35 +++
 rtl/axum_uart_rx.sv | 155 +++++++++++++++
 tb/tb_axum_uart_rx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axum_uart_pkg.sv
// Shared types and constants for the axum UART receive and transmit stages.
package axum_uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } uart_rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_START  = 7;

endpackage

// File: rtl/axum_uart_baud_gen.sv
// Oversample tick generator: one tick every dvsr_i+1 clocks while enabled.
module axum_uart_baud_gen #(
    parameter int DVSR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DVSR_W-1:0] dvsr_i,
    output logic              tick_o
);

    logic [DVSR_W-1:0] cnt_q;
    logic [DVSR_W-1:0] cnt_d;
    logic              wrap;

    // >= rather than == so a divisor lowered mid-count never wraps through 2^DVSR_W
    assign wrap   = (cnt_q >= dvsr_i);
    assign tick_o = en_i & wrap;

    always_comb begin
        cnt_d = cnt_q + DVSR_W'(1);
        if (!en_i || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axum_uart_rx.sv
// 8N1 serial receiver: synchronises rx_i, oversamples at 16x and pushes
// completed bytes to the RX FIFO, flagging framing and overrun errors.
module axum_uart_rx
    import axum_uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    input  logic              en_i,
    input  logic [DVSR_W-1:0] dvsr_i,
    input  logic              rx_full_i,
    input  logic              err_clr_i,
    output logic [DBIT-1:0]   rx_data_o,
    output logic              rx_valid_o,
    output logic              frame_err_o,
    output logic              overrun_err_o,
    output logic              busy_o
);

    localparam int S_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_prev_q;
    logic start_edge;
    logic tick;

    uart_rx_state_e  state_q;
    logic [S_W-1:0]  s_q;
    logic [N_W-1:0]  n_q;
    logic [DBIT-1:0] b_q;
    logic [DBIT-1:0] rx_data_q;
    logic            rx_valid_q;
    logic            frame_err_q;
    logic            overrun_err_q;

    axum_uart_baud_gen #(
        .DVSR_W (DVSR_W)
    ) u_baud (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .dvsr_i (dvsr_i),
        .tick_o (tick)
    );

    // Two-flop synchroniser plus one history flop; flops idle high like the line
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign start_edge = rx_prev_q & ~rx_sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= RX_IDLE;
            s_q           <= '0;
            n_q           <= '0;
            b_q           <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            // Clear is applied first so a set later in this block wins
            if (err_clr_i) begin
                frame_err_q   <= 1'b0;
                overrun_err_q <= 1'b0;
            end
            if (!en_i) begin
                state_q <= RX_IDLE;
                s_q     <= '0;
                n_q     <= '0;
            end else begin
                case (state_q)
                    RX_IDLE: begin
                        if (start_edge) begin
                            state_q <= RX_START;
                            s_q     <= '0;
                        end
                    end
                    RX_START: begin
                        if (tick) begin
                            if (s_q == S_W'(MID_START)) begin
                                s_q <= '0;
                                n_q <= '0;
                                // A start bit gone high by mid-bit is line noise
                                state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                            end else begin
                                s_q <= s_q + S_W'(1);
                            end
                        end
                    end
                    RX_DATA: begin
                        if (tick) begin
                            if (s_q == S_W'(OVERSAMPLE - 1)) begin
                                s_q <= '0;
                                b_q <= {rx_sync_q, b_q[DBIT-1:1]};
                                if (n_q == N_W'(DBIT - 1)) begin
                                    state_q <= RX_STOP;
                                end else begin
                                    n_q <= n_q + N_W'(1);
                                end
                            end else begin
                                s_q <= s_q + S_W'(1);
                            end
                        end
                    end
                    RX_STOP: begin
                        if (tick) begin
                            if (s_q == S_W'(SB_TICK - 1)) begin
                                state_q <= RX_IDLE;
                                s_q     <= '0;
                                if (!rx_sync_q) begin
                                    frame_err_q <= 1'b1;
                                end else if (rx_full_i) begin
                                    overrun_err_q <= 1'b1;
                                end else begin
                                    rx_data_q  <= b_q;
                                    rx_valid_q <= 1'b1;
                                end
                            end else begin
                                s_q <= s_q + S_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= RX_IDLE;
                    end
                endcase
            end
        end
    end

    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign frame_err_o   = frame_err_q;
    assign overrun_err_o = overrun_err_q;
    assign busy_o        = (state_q != RX_IDLE);

endmodule

// File: tb/tb_axum_uart_rx.sv
// Self-checking bench for axum_uart_rx: frame table plus hand-built corner sequences.
module tb_axum_uart_rx;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rx_i;
    logic        en_i;
    logic [31:0] dvsr_i;
    logic        rx_full_i;
    logic        err_clr_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        frame_err_o;
    logic        overrun_err_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fall_cyc = -1;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       full;
        logic       exp_fe;
        logic       exp_ov;
    } vec_t;

    vec_t tbl[4];

    axum_uart_rx #(
        .DBIT    (8),
        .SB_TICK (16),
        .DVSR_W  (32)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .rx_i          (rx_i),
        .en_i          (en_i),
        .dvsr_i        (dvsr_i),
        .rx_full_i     (rx_full_i),
        .err_clr_i     (err_clr_i),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .frame_err_o   (frame_err_o),
        .overrun_err_o (overrun_err_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    // Output monitor: every push must match the oldest expected byte and last one cycle
    always @(negedge clk_i) begin
        if (rx_valid_o) begin
            checks++;
            if (prev_valid) begin
                errors++;
                $display("FAIL valid_width: rx_valid_o high two cycles in a row, required one");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_push: got data %02h, no push expected", rx_data_o);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rx_data_o !== e) begin
                    errors++;
                    $display("FAIL push_data: got %02h expected %02h", rx_data_o, e);
                end
            end
        end
        if (prev_valid && !rx_valid_o) fall_cyc = cyc;
        prev_valid = rx_valid_o;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int k);
        repeat (k) @(negedge clk_i);
    endtask

    task automatic clr_pulse();
        err_clr_i = 1'b1;
        wait_clks(1);
        err_clr_i = 1'b0;
    endtask

    // Drives start, 8 data bits LSB first and the stop bit; line is left at the stop value
    task automatic send_frame(input logic [7:0] d, input logic stop);
        int bc;
        bc = 16 * (int'(dvsr_i) + 1);
        rx_i = 1'b0;
        wait_clks(bc);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            wait_clks(bc);
        end
        rx_i = stop;
        wait_clks(bc);
    endtask

    initial begin
        int t0;
        int busy_hits;
        bit seen;

        tbl[0] = '{data: 8'h81, stop: 1'b1, full: 1'b0, exp_fe: 1'b0, exp_ov: 1'b0};
        tbl[1] = '{data: 8'h77, stop: 1'b1, full: 1'b1, exp_fe: 1'b0, exp_ov: 1'b1};
        tbl[2] = '{data: 8'hC3, stop: 1'b0, full: 1'b0, exp_fe: 1'b1, exp_ov: 1'b0};
        tbl[3] = '{data: 8'h5A, stop: 1'b1, full: 1'b0, exp_fe: 1'b0, exp_ov: 1'b0};

        rst_i = 1'b1; rx_i = 1'b1; en_i = 1'b1; dvsr_i = 32'd0;
        rx_full_i = 1'b0; err_clr_i = 1'b0;
        wait_clks(4);
        chk("reset_data", rx_data_o, 8'h00);
        chk("reset_valid", rx_valid_o, 1'b0);
        chk("reset_fe", frame_err_o, 1'b0);
        chk("reset_ov", overrun_err_o, 1'b0);
        chk("reset_busy", busy_o, 1'b0);
        rst_i = 1'b0;
        wait_clks(4);

        // Basic receive with latency window
        t0 = cyc;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_clks(40);
        checks++;
        if (fall_cyc - t0 < 150 || fall_cyc - t0 > 160) begin
            errors++;
            $display("FAIL push_latency: valid fell %0d clocks after line fall, required 150..160", fall_cyc - t0);
        end
        chk("basic_hold", rx_data_o, 8'hA5);
        chk("basic_fe", frame_err_o, 1'b0);
        chk("basic_ov", overrun_err_o, 1'b0);
        chk("basic_queue", exp_q.size(), 0);

        // Start glitch
        rx_i = 1'b0;
        wait_clks(4);
        rx_i = 1'b1;
        wait_clks(1);
        chk("glitch_busy_hi", busy_o, 1'b1);
        wait_clks(20);
        chk("glitch_busy_lo", busy_o, 1'b0);
        chk("glitch_fe", frame_err_o, 1'b0);
        chk("glitch_ov", overrun_err_o, 1'b0);

        // Table of single frames
        for (int i = 0; i < 4; i++) begin
            clr_pulse();
            rx_full_i = tbl[i].full;
            if (tbl[i].stop && !tbl[i].full) exp_q.push_back(tbl[i].data);
            send_frame(tbl[i].data, tbl[i].stop);
            rx_i = 1'b1;
            wait_clks(48);
            rx_full_i = 1'b0;
            chk($sformatf("tbl%0d_fe", i), frame_err_o, tbl[i].exp_fe);
            chk($sformatf("tbl%0d_ov", i), overrun_err_o, tbl[i].exp_ov);
            chk($sformatf("tbl%0d_queue", i), exp_q.size(), 0);
        end

        // Framing error then long break, then a good frame
        clr_pulse();
        send_frame(8'h3C, 1'b0);
        wait_clks(4);
        chk("break_fe", frame_err_o, 1'b1);
        busy_hits = 0;
        for (int i = 0; i < 40 * 16; i++) begin
            wait_clks(1);
            if (busy_o) busy_hits++;
        end
        chk("break_busy_cycles", busy_hits, 0);
        rx_i = 1'b1;
        wait_clks(32);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        wait_clks(48);
        chk("break_next_data", rx_data_o, 8'h12);
        chk("break_fe_sticky", frame_err_o, 1'b1);
        chk("break_queue", exp_q.size(), 0);

        // Overrun, clear, and clear colliding with a new overrun
        clr_pulse();
        rx_full_i = 1'b1;
        send_frame(8'h77, 1'b1);
        wait_clks(16);
        chk("ovr_set", overrun_err_o, 1'b1);
        clr_pulse();
        wait_clks(1);
        chk("ovr_cleared", overrun_err_o, 1'b0);
        err_clr_i = 1'b1;
        seen = 1'b0;
        fork
            send_frame(8'h77, 1'b1);
            begin
                for (int i = 0; i < 400 && !seen; i++) begin
                    @(negedge clk_i);
                    if (overrun_err_o) begin
                        seen = 1'b1;
                        err_clr_i = 1'b0;
                    end
                end
                err_clr_i = 1'b0;
            end
        join
        chk("ovr_set_wins_seen", seen, 1'b1);
        wait_clks(4);
        chk("ovr_set_wins_hold", overrun_err_o, 1'b1);
        rx_full_i = 1'b0;
        clr_pulse();

        // Back-to-back frames at 64 clocks per bit
        dvsr_i = 32'd3;
        wait_clks(8);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clks(200);
        chk("b2b_queue", exp_q.size(), 0);
        chk("b2b_last", rx_data_o, 8'hFF);

        // Divisor lowered mid-count takes effect at once
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk_i);
            if (dut.u_baud.cnt_q == 32'd2) seen = 1'b1;
        end
        chk("dvsr_cnt2_seen", seen, 1'b1);
        dvsr_i = 32'd1;
        #1;
        chk("dvsr_tick_now", dut.u_baud.tick_o, 1'b1);
        @(posedge clk_i);
        #1;
        chk("dvsr_cnt_wrapped", dut.u_baud.cnt_q, 32'd0);
        @(negedge clk_i);
        dvsr_i = 32'd0;
        wait_clks(4);

        // Reset in the DATA state
        rx_i = 1'b0;
        wait_clks(60);
        chk("rst_busy_before", busy_o, 1'b1);
        rst_i = 1'b1;
        rx_i  = 1'b1;
        wait_clks(1);
        chk("rst_mid_data", rx_data_o, 8'h00);
        chk("rst_mid_valid", rx_valid_o, 1'b0);
        chk("rst_mid_fe", frame_err_o, 1'b0);
        chk("rst_mid_ov", overrun_err_o, 1'b0);
        chk("rst_mid_busy", busy_o, 1'b0);
        rst_i = 1'b0;
        wait_clks(8);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_clks(48);
        chk("rst_next_data", rx_data_o, 8'h5A);
        chk("rst_next_queue", exp_q.size(), 0);

        // Enable dropped in the DATA state
        rx_i = 1'b0;
        wait_clks(60);
        chk("en_busy_before", busy_o, 1'b1);
        en_i = 1'b0;
        rx_i = 1'b1;
        wait_clks(1);
        chk("en_drop_idle", busy_o, 1'b0);
        en_i = 1'b1;
        wait_clks(200);
        chk("en_drop_fe", frame_err_o, 1'b0);
        chk("en_drop_ov", overrun_err_o, 1'b0);
        chk("en_drop_data", rx_data_o, 8'h5A);
        chk("final_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
